// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and default frame geometry.
package uart_pkg;

  localparam int DEFAULT_DATA_BITS  = 8;
  localparam int DEFAULT_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: oversample tick and serial line in, received byte and status pulses out.
interface uart_rx_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS
);

  logic                 s_tick;
  logic                 rx;
  logic [DATA_BITS-1:0] d_out;
  logic                 rx_done;
  logic                 frame_err;

  modport master (
    output s_tick,
    output rx,
    input  d_out,
    input  rx_done,
    input  frame_err
  );

  modport slave (
    input  s_tick,
    input  rx,
    output d_out,
    output rx_done,
    output frame_err
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; both flops reset to RESET_VAL.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [1:0] sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= {2{RESET_VAL}};
    end else begin
      sync_reg <= {sync_reg[0], d};
    end
  end

  assign q = sync_reg[1];

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start-bit validation at mid-bit, LSB-first data capture,
// stop-bit check with one-shot framing error and break (held-low) suppression.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEFAULT_DATA_BITS,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_rx_if.slave bus
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(DATA_BITS - 1);

  logic rx_s;

  uart_state_e          state_reg,     state_next;
  logic [CNT_W-1:0]     cnt_reg,       cnt_next;
  logic [IDX_W-1:0]     idx_reg,       idx_next;
  logic [DATA_BITS-1:0] shift_reg,     shift_next;
  logic [DATA_BITS-1:0] d_out_reg,     d_out_next;
  logic                 rx_done_reg,   rx_done_next;
  logic                 frame_err_reg, frame_err_next;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (bus.rx),
    .q    (rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      idx_reg       <= '0;
      shift_reg     <= '0;
      d_out_reg     <= '0;
      rx_done_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      idx_reg       <= idx_next;
      shift_reg     <= shift_next;
      d_out_reg     <= d_out_next;
      rx_done_reg   <= rx_done_next;
      frame_err_reg <= frame_err_next;
    end
  end

  // Nothing moves between ticks, so every transition below is gated by s_tick.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    idx_next       = idx_reg;
    shift_next     = shift_reg;
    d_out_next     = d_out_reg;
    rx_done_next   = 1'b0;
    frame_err_next = 1'b0;

    if (bus.s_tick) begin
      case (state_reg)
        IDLE: begin
          if (!rx_s) begin
            state_next = START;
            cnt_next   = '0;
          end
        end

        START: begin
          if (cnt_reg == HALF_LAST) begin
            cnt_next = '0;
            if (!rx_s) begin
              state_next = DATA;
              idx_next   = '0;
            end else begin
              // Line went back high before mid-bit: a glitch, not a start bit.
              state_next = IDLE;
            end
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end

        DATA: begin
          if (cnt_reg == FULL_LAST) begin
            cnt_next   = '0;
            shift_next = {rx_s, shift_reg[DATA_BITS-1:1]};
            if (idx_reg == LAST_BIT) begin
              state_next = STOP;
            end else begin
              idx_next = idx_reg + 1'b1;
            end
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end

        STOP: begin
          if (cnt_reg == FULL_LAST) begin
            cnt_next = '0;
            if (rx_s) begin
              d_out_next   = shift_reg;
              rx_done_next = 1'b1;
              state_next   = IDLE;
            end else begin
              frame_err_next = 1'b1;
              state_next     = WAIT_HIGH;
            end
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end

        WAIT_HIGH: begin
          // A break keeps the line low; only its release re-arms start detection.
          if (rx_s) begin
            state_next = IDLE;
          end
        end

        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  assign bus.d_out     = d_out_reg;
  assign bus.rx_done   = rx_done_reg;
  assign bus.frame_err = frame_err_reg;

endmodule
